id_decode: RTL and testbench
============================

# id_decode

Instruction-decode pipeline stage for the MIPS pipeline. It accepts a 32-bit instruction word from IF and produces one registered ID/EX control bundle. The bundle holds the 4-bit ALU operation code consumed by the EX-stage ALU, plus operand selects, the extended immediate, register indices and memory/branch controls. It is the producer side of the ALU op encoding and owns the funct/opcode-to-ALU-op mapping. It also provides valid/ready flow control, flush, and a saturating illegal-instruction counter.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage can accept instr this cycle
- instr  in  32  instruction word
- flush  in  1  discard held bundle and incoming instr
- out_valid  out  1  bundle valid
- out_ready  in  1  EX accepts bundle
- alu_op  out  4  ALU operation code (package alu_op_t)
- v1_sel  out  1  0: v1 = GPR[rs]; 1: v1 = imm32 (shift amount)
- v2_sel  out  1  0: v2 = GPR[rt]; 1: v2 = imm32
- imm32  out  32  extended immediate or zero-extended shamt
- rs, rt, rd_dst  out  5 each  source indices, write-back destination
- reg_write, mem_read, mem_write, branch_eq, branch_ne  out  1 each  controls
- illegal  out  1  bundle is an unsupported instruction
- illegal_count  out  8  saturating count of illegal instrs accepted

## Operation
- ALU op codes:
  - ADD 1100, SUB 1110, AND 1000, OR 1001, XOR 1010, NOR 1011, SLT 0110
  - SLL 0000, SRL 0010, SRA 0011, PASS_V2 1111
  - Default ALU behaviour for unlisted codes is 0, so the decoder must never emit them for legal instructions.
- R-type, opcode 000000:
  - add/addu → ADD; sub/subu → SUB; and, or, xor, nor, slt map directly.
  - For the ALU-class functs (10xxxx, excluding addu/subu), alu_op = funct[3:0] ^ {funct[5], funct[5], 2'b00}.
  - addu/subu have funct[0] cleared before mapping.
  - rd_dst = rd, reg_write = 1, v2_sel = 0.
- Shifts:
  - sll/srl/sra (funct 000000/000010/000011): alu_op = {2'b00, funct[1:0]}, v1_sel = 1, imm32 = {27'b0, shamt}.
  - sllv/srlv/srav (000100/000110/000111): same alu_op, v1_sel = 0.
- I-type: v2_sel = 1, rd_dst = rt.
  - addi/addiu → ADD, sign-extended.
  - slti → SLT, sign-extended.
  - andi/ori/xori → AND/OR/XOR, zero-extended.
  - lui → PASS_V2, imm32 = {imm16, 16'b0}.
  - lw → ADD, sign-extended, mem_read = 1, reg_write = 1.
  - sw → ADD, sign-extended, mem_write = 1, reg_write = 0.
  - beq/bne → SUB, v2_sel = 0, branch_eq/branch_ne = 1, reg_write = 0.
- Any other opcode/funct, including funct 000001:
  - illegal = 1, alu_op = 0000, all write/mem/branch controls 0.
  - illegal_count increments once per accepted illegal instr and saturates at 255.
- Sequential behaviour:
  - Outputs come from a single bundle register; combinational decode feeds it.
  - in_ready = !out_valid || out_ready. This is combinational, with no skid buffer.
  - Load when in_valid && in_ready && !flush. out_valid ← 1 on load, else 0 when out_ready.
  - Bundle fields hold steady while out_valid && !out_ready.

## Timing
- Latency: 1 cycle, instr accepted at edge N → bundle visible after edge N.
- Throughput: 1 instr/cycle while out_ready = 1.
- Reset (async assert, sync-safe deassert): out_valid = 0, all bundle fields 0, alu_op = 0000, illegal = 0, illegal_count = 0. in_ready = 1 immediately.
- flush:
  - Next edge: out_valid = 0.
  - The concurrent incoming instr is consumed and dropped: in_ready is still driven per the formula, and illegal_count does not increment.
  - Bundle fields may retain stale values; downstream must qualify them with out_valid.
- Simultaneous load and out_ready with out_valid = 1: new bundle replaces old in the same edge. No bubble.
- Stall: in_ready = 0; instr must be held by IF.
- Reset mid-stall drops the held bundle.

## Structure
- alu_pkg (shared with the ALU): alu_op_t enum with the code values above; opcode and funct localparams.
- Sub-module alu_op_decode: purely combinational, instr → next bundle fields plus illegal.
- id_decode holds the register, handshake, flush and counter.

## Test plan
- 0x00221820 (add $3,$1,$2) → alu_op 1100, rs 1, rt 2, rd_dst 3, reg_write 1, v1_sel 0, v2_sel 0, out_valid one cycle later.
- 0x2885FFFF (slti $5,$4,-1) → alu_op 0110, imm32 0xFFFFFFFF, v2_sel 1, rd_dst 5. Then 0x3485FFFF (ori) → alu_op 1001, imm32 0x0000FFFF.
- 0x3C011234 (lui) → alu_op 1111, imm32 0x12340000. 0x00031100 (sll $2,$3,4) → alu_op 0000, v1_sel 1, imm32 4, rd_dst 2.
- Back-to-back stream of 4 instrs with out_ready held 0 for 3 cycles mid-stream → bundle stable, in_ready 0 during stall, no instr lost or duplicated.
- flush asserted with out_valid = 1 and in_valid = 1 → next cycle out_valid 0, dropped instr never appears.
- 300 accepted instrs of 0xFC000000 → illegal 1, alu_op 0000, illegal_count saturates at 255. rst_n low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared between the ID-stage decoder and the EX-stage ALU.
// Holds the ALU operation encoding, MIPS opcode/funct values and the
// ID/EX control bundle layout.
package alu_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned OPCODE_W  = 6;
   localparam int unsigned FUNCT_W   = 6;
   localparam int unsigned SHAMT_W   = 5;
   localparam int unsigned IMM16_W   = 16;
   localparam int unsigned IMM32_W   = 32;
   localparam int unsigned ALU_OP_W  = 4;
   localparam int unsigned CNT_W     = 8;

   // ALU operation codes; unlisted codes make the ALU output zero
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_SLL     = 4'b0000,
      ALU_SRL     = 4'b0010,
      ALU_SRA     = 4'b0011,
      ALU_SLT     = 4'b0110,
      ALU_AND     = 4'b1000,
      ALU_OR      = 4'b1001,
      ALU_XOR     = 4'b1010,
      ALU_NOR     = 4'b1011,
      ALU_ADD     = 4'b1100,
      ALU_SUB     = 4'b1110,
      ALU_PASS_V2 = 4'b1111
   } alu_op_t;

   // Opcodes
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

   // R-type funct codes
   localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
   localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
   localparam logic [FUNCT_W-1:0] F_SRA  = 6'b000011;
   localparam logic [FUNCT_W-1:0] F_SLLV = 6'b000100;
   localparam logic [FUNCT_W-1:0] F_SRLV = 6'b000110;
   localparam logic [FUNCT_W-1:0] F_SRAV = 6'b000111;
   localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
   localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
   localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
   localparam logic [FUNCT_W-1:0] F_SUBU = 6'b100011;
   localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
   localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
   localparam logic [FUNCT_W-1:0] F_XOR  = 6'b100110;
   localparam logic [FUNCT_W-1:0] F_NOR  = 6'b100111;
   localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;

   // ID/EX control bundle
   typedef struct packed {
      alu_op_t                alu_op;
      logic                   v1_sel;
      logic                   v2_sel;
      logic [IMM32_W-1:0]     imm32;
      logic [REG_IDX_W-1:0]   rs;
      logic [REG_IDX_W-1:0]   rt;
      logic [REG_IDX_W-1:0]   rd_dst;
      logic                   reg_write;
      logic                   mem_read;
      logic                   mem_write;
      logic                   branch_eq;
      logic                   branch_ne;
      logic                   illegal;
   } id_bundle_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational instruction decode into the next ID/EX bundle.
//   instr    in  32  instruction word
//   bundle_c out     decoded control bundle (illegal set for unsupported instrs)
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output id_bundle_t         bundle_c
);

   logic [OPCODE_W-1:0]  opcode;
   logic [FUNCT_W-1:0]   funct;
   logic [REG_IDX_W-1:0] rs_f;
   logic [REG_IDX_W-1:0] rt_f;
   logic [REG_IDX_W-1:0] rd_f;
   logic [SHAMT_W-1:0]   shamt;
   logic [IMM16_W-1:0]   imm16;
   logic [IMM32_W-1:0]   imm_sext;
   logic [IMM32_W-1:0]   imm_zext;

   assign opcode   = instr[31:26];
   assign rs_f     = instr[25:21];
   assign rt_f     = instr[20:16];
   assign rd_f     = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm16    = instr[15:0];
   assign imm_sext = {{(IMM32_W-IMM16_W){imm16[IMM16_W-1]}}, imm16};
   assign imm_zext = {{(IMM32_W-IMM16_W){1'b0}}, imm16};

   logic               illegal_c;
   logic [FUNCT_W-1:0] fm_c;

   // Opcode/funct to bundle mapping
   always_comb begin
      bundle_c    = '0;
      illegal_c   = 1'b0;
      fm_c        = funct;
      bundle_c.rs = rs_f;
      bundle_c.rt = rt_f;

      case (opcode)
         OP_RTYPE: begin
            bundle_c.rd_dst    = rd_f;
            bundle_c.reg_write = 1'b1;
            case (funct)
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                  // addu/subu share add/sub encodings once bit 0 is dropped
                  if (funct == F_ADDU || funct == F_SUBU) begin
                     fm_c[0] = 1'b0;
                  end
                  bundle_c.alu_op = alu_op_t'(4'(fm_c[3:0] ^ {fm_c[5], fm_c[5], 2'b00}));
               end
               F_SLL, F_SRL, F_SRA: begin
                  bundle_c.alu_op = alu_op_t'({2'b00, funct[1:0]});
                  bundle_c.v1_sel = 1'b1;
                  bundle_c.imm32  = {{(IMM32_W-SHAMT_W){1'b0}}, shamt};
               end
               F_SLLV, F_SRLV, F_SRAV: begin
                  bundle_c.alu_op = alu_op_t'({2'b00, funct[1:0]});
               end
               default: illegal_c = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            bundle_c.alu_op    = ALU_ADD;
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = imm_sext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.reg_write = 1'b1;
         end
         OP_SLTI: begin
            bundle_c.alu_op    = ALU_SLT;
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = imm_sext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.reg_write = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            // andi/ori/xori low opcode bits pick AND/OR/XOR directly
            bundle_c.alu_op    = alu_op_t'({2'b10, opcode[1:0]});
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = imm_zext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.reg_write = 1'b1;
         end
         OP_LUI: begin
            bundle_c.alu_op    = ALU_PASS_V2;
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = {imm16, {(IMM32_W-IMM16_W){1'b0}}};
            bundle_c.rd_dst    = rt_f;
            bundle_c.reg_write = 1'b1;
         end
         OP_LW: begin
            bundle_c.alu_op    = ALU_ADD;
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = imm_sext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.reg_write = 1'b1;
            bundle_c.mem_read  = 1'b1;
         end
         OP_SW: begin
            bundle_c.alu_op    = ALU_ADD;
            bundle_c.v2_sel    = 1'b1;
            bundle_c.imm32     = imm_sext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.mem_write = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            // compare rs against rt; imm carries the branch offset
            bundle_c.alu_op    = ALU_SUB;
            bundle_c.imm32     = imm_sext;
            bundle_c.rd_dst    = rt_f;
            bundle_c.branch_eq = (opcode == OP_BEQ);
            bundle_c.branch_ne = (opcode == OP_BNE);
         end
         default: illegal_c = 1'b1;
      endcase

      // Unsupported instructions leave a clean all-zero bundle behind
      if (illegal_c) begin
         bundle_c         = '0;
         bundle_c.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/id_decode.sv
// id_decode: MIPS ID pipeline stage with one registered ID/EX bundle.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   IF-side handshake (in_ready combinational)
//   instr               instruction word
//   flush               drop held bundle and concurrent instr
//   out_valid/out_ready EX-side handshake
//   alu_op..illegal     registered bundle fields
//   illegal_count       saturating count of accepted illegal instrs
module id_decode
   import alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   instr,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output alu_op_t              alu_op,
   output logic                 v1_sel,
   output logic                 v2_sel,
   output logic [IMM32_W-1:0]   imm32,
   output logic [REG_IDX_W-1:0] rs,
   output logic [REG_IDX_W-1:0] rt,
   output logic [REG_IDX_W-1:0] rd_dst,
   output logic                 reg_write,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 branch_eq,
   output logic                 branch_ne,
   output logic                 illegal,
   output logic [CNT_W-1:0]     illegal_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   id_bundle_t       dec_c;
   id_bundle_t       bundle_q, bundle_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_c;

   alu_op_decode u_dec (
      .instr    (instr),
      .bundle_c (dec_c)
   );

   // Single-entry stage: accept whenever the slot is empty or draining
   assign in_ready = !out_valid_q || out_ready;
   assign load_c   = in_valid && in_ready && !flush;

   // Next bundle, valid and counter
   always_comb begin
      bundle_d    = bundle_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;

      if (load_c) begin
         bundle_d = dec_c;
      end

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (load_c) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (load_c && dec_c.illegal && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Bundle register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bundle_q    <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         bundle_q    <= bundle_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_op        = bundle_q.alu_op;
   assign v1_sel        = bundle_q.v1_sel;
   assign v2_sel        = bundle_q.v2_sel;
   assign imm32         = bundle_q.imm32;
   assign rs            = bundle_q.rs;
   assign rt            = bundle_q.rt;
   assign rd_dst        = bundle_q.rd_dst;
   assign reg_write     = bundle_q.reg_write;
   assign mem_read      = bundle_q.mem_read;
   assign mem_write     = bundle_q.mem_write;
   assign branch_eq     = bundle_q.branch_eq;
   assign branch_ne     = bundle_q.branch_ne;
   assign illegal       = bundle_q.illegal;
   assign illegal_count = cnt_q;

endmodule

// File: tb/tb_id_decode.sv
// tb_id_decode: randomized bench for id_decode against a spec-level model.
module tb_id_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic        v1_sel, v2_sel;
   logic [31:0] imm32;
   logic [4:0]  rs, rt, rd_dst;
   logic        reg_write, mem_read, mem_write, branch_eq, branch_ne, illegal;
   logic [7:0]  illegal_count;

   always #5 clk = ~clk;

   id_decode dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .instr         (instr),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .alu_op        (alu_op),
      .v1_sel        (v1_sel),
      .v2_sel        (v2_sel),
      .imm32         (imm32),
      .rs            (rs),
      .rt            (rt),
      .rd_dst        (rd_dst),
      .reg_write     (reg_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .branch_eq     (branch_eq),
      .branch_ne     (branch_ne),
      .illegal       (illegal),
      .illegal_count (illegal_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Expected decode of one instruction
   typedef struct {
      logic [3:0]  op;
      logic        v1, v2;
      logic [31:0] imm;
      logic [4:0]  rs, rt, rd;
      logic        rw, mr, mw, beq, bne, ill;
   } exp_t;

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t        e;
      logic [31:0] sx, zx;
      bit          ok = 1'b1;
      e = '{op: 4'h0, v1: 1'b0, v2: 1'b0, imm: 32'h0, rs: w[25:21], rt: w[20:16],
            rd: 5'h0, rw: 1'b0, mr: 1'b0, mw: 1'b0, beq: 1'b0, bne: 1'b0, ill: 1'b0};
      sx = {{16{w[15]}}, w[15:0]};
      zx = {16'h0, w[15:0]};
      case (w[31:26])
         6'h00: begin
            e.rd = w[15:11];
            e.rw = 1'b1;
            case (w[5:0])
               6'h20, 6'h21: e.op = 4'hC;
               6'h22, 6'h23: e.op = 4'hE;
               6'h24: e.op = 4'h8;
               6'h25: e.op = 4'h9;
               6'h26: e.op = 4'hA;
               6'h27: e.op = 4'hB;
               6'h2A: e.op = 4'h6;
               6'h00: begin e.op = 4'h0; e.v1 = 1'b1; e.imm = 32'(w[10:6]); end
               6'h02: begin e.op = 4'h2; e.v1 = 1'b1; e.imm = 32'(w[10:6]); end
               6'h03: begin e.op = 4'h3; e.v1 = 1'b1; e.imm = 32'(w[10:6]); end
               6'h04: e.op = 4'h0;
               6'h06: e.op = 4'h2;
               6'h07: e.op = 4'h3;
               default: ok = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin e.op = 4'hC; e.v2 = 1'b1; e.imm = sx; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h0A: begin e.op = 4'h6; e.v2 = 1'b1; e.imm = sx; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h0C: begin e.op = 4'h8; e.v2 = 1'b1; e.imm = zx; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h0D: begin e.op = 4'h9; e.v2 = 1'b1; e.imm = zx; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h0E: begin e.op = 4'hA; e.v2 = 1'b1; e.imm = zx; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h0F: begin e.op = 4'hF; e.v2 = 1'b1; e.imm = {w[15:0], 16'h0}; e.rd = w[20:16]; e.rw = 1'b1; end
         6'h23: begin e.op = 4'hC; e.v2 = 1'b1; e.imm = sx; e.rd = w[20:16]; e.rw = 1'b1; e.mr = 1'b1; end
         6'h2B: begin e.op = 4'hC; e.v2 = 1'b1; e.imm = sx; e.rd = w[20:16]; e.mw = 1'b1; end
         6'h04: begin e.op = 4'hE; e.rd = w[20:16]; e.beq = 1'b1; end
         6'h05: begin e.op = 4'hE; e.rd = w[20:16]; e.bne = 1'b1; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.op = 4'h0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
         e.beq = 1'b0; e.bne = 1'b0; e.ill = 1'b1;
      end
      return e;
   endfunction

   // Model of the stage as seen from outside
   bit   m_valid;
   exp_t m_b;
   int   m_cnt;

   task automatic check_outputs();
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("illegal_count", 32'(illegal_count), 32'(m_cnt));
      if (m_valid) begin
         check("alu_op", 32'(alu_op), 32'(m_b.op));
         check("illegal", 32'(illegal), 32'(m_b.ill));
         check("ctrl", {27'h0, reg_write, mem_read, mem_write, branch_eq, branch_ne},
               {27'h0, m_b.rw, m_b.mr, m_b.mw, m_b.beq, m_b.bne});
         if (!m_b.ill) begin
            check("sel", {30'h0, v1_sel, v2_sel}, {30'h0, m_b.v1, m_b.v2});
            check("regs", {17'h0, rs, rt, rd_dst}, {17'h0, m_b.rs, m_b.rt, m_b.rd});
            if (m_b.v1 || m_b.v2) check("imm32", imm32, m_b.imm);
         end
      end
   endtask

   // One clock: drive inputs, check in_ready, advance model, check outputs
   task automatic cycle(input logic iv, input logic [31:0] ins, input logic fl,
                        input logic ordy, output bit consumed);
      bit   exp_ir, ld, n_valid;
      exp_t n_b;
      int   n_cnt;
      in_valid  = iv;
      instr     = ins;
      flush     = fl;
      out_ready = ordy;
      #1;
      exp_ir = !m_valid || ordy;
      check("in_ready", 32'(in_ready), 32'(exp_ir));
      ld       = iv && exp_ir && !fl;
      consumed = iv && exp_ir;
      n_b      = ld ? ref_decode(ins) : m_b;
      n_valid  = fl ? 1'b0 : (ld ? 1'b1 : (ordy ? 1'b0 : m_valid));
      n_cnt    = (ld && n_b.ill && m_cnt < 255) ? m_cnt + 1 : m_cnt;
      @(posedge clk);
      #1;
      m_valid = n_valid;
      m_b     = n_b;
      m_cnt   = n_cnt;
      check_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " out_valid"}, 32'(out_valid), 32'h0);
      check({tag, " in_ready"}, 32'(in_ready), 32'h1);
      check({tag, " alu_op"}, 32'(alu_op), 32'h0);
      check({tag, " imm32"}, imm32, 32'h0);
      check({tag, " regs"}, {17'h0, rs, rt, rd_dst}, 32'h0);
      check({tag, " flags"}, {24'h0, v1_sel, v2_sel, reg_write, mem_read, mem_write,
                              branch_eq, branch_ne, illegal}, 32'h0);
      check({tag, " illegal_count"}, 32'(illegal_count), 32'h0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fn_tab [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20,
                                   6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
      logic [5:0]  op_tab [11] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                                   6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      logic [31:0] w = $urandom;
      int          r = $urandom_range(0, 15);
      if (r < 3) begin
         w[31:26] = 6'h00;
         w[5:0]   = fn_tab[$urandom_range(0, 14)];
      end else if (r == 3) begin
         w[31:26] = 6'h00;
      end else if (r < 14) begin
         w[31:26] = op_tab[$urandom_range(0, 10)];
      end
      return w;
   endfunction

   initial begin
      bit          c;
      logic [31:0] pend;
      bit          holding;
      logic [31:0] stream [4] = '{32'h00221820, 32'h2885FFFF, 32'h3C011234, 32'h00031100};
      int          si;

      rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
      m_valid = 1'b0; m_cnt = 0; m_b = ref_decode(32'hFC000000);
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      cycle(1'b1, 32'h00221820, 1'b0, 1'b1, c);
      check("add alu_op", 32'(alu_op), 32'hC);
      check("add rd_dst", 32'(rd_dst), 32'h3);
      cycle(1'b1, 32'h2885FFFF, 1'b0, 1'b1, c);
      check("slti imm32", imm32, 32'hFFFFFFFF);
      cycle(1'b1, 32'h3485FFFF, 1'b0, 1'b1, c);
      check("ori imm32", imm32, 32'h0000FFFF);
      cycle(1'b1, 32'h3C011234, 1'b0, 1'b1, c);
      check("lui imm32", imm32, 32'h12340000);
      cycle(1'b1, 32'h00031100, 1'b0, 1'b1, c);
      check("sll imm32", imm32, 32'h4);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, c);

      // Stream of 4 with a 3-cycle stall in the middle
      si = 0;
      for (int k = 0; k < 12 && si < 4; k++) begin
         cycle(1'b1, stream[si], 1'b0, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, c);
         if (c) si++;
      end
      check("stream all accepted", 32'(si), 32'h4);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, c);

      // Flush with a valid bundle and incoming instr
      cycle(1'b1, 32'h00221820, 1'b0, 1'b0, c);
      cycle(1'b1, 32'h3C01BEEF, 1'b1, 1'b1, c);
      check("flush out_valid", 32'(out_valid), 32'h0);
      cycle(1'b1, 32'h2885FFFF, 1'b0, 1'b1, c);
      check("post-flush alu_op", 32'(alu_op), 32'h6);

      // Randomized traffic; IF holds an instr until consumed
      holding = 1'b0;
      pend    = '0;
      for (int k = 0; k < 2000; k++) begin
         bit iv;
         if (!holding) begin
            pend = rand_instr();
            iv   = ($urandom_range(0, 3) != 0);
         end else begin
            iv = 1'b1;
         end
         cycle(iv, pend, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), c);
         holding = iv && !c;
      end

      // Illegal saturation
      rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) cycle(1'b1, 32'hFC000000, 1'b0, 1'b1, c);
      check("sat count", 32'(illegal_count), 32'd255);
      check("sat illegal", 32'(illegal), 32'h1);
      check("sat alu_op", 32'(alu_op), 32'h0);

      // Reset asserted mid-stream, between edges
      cycle(1'b1, 32'h00221820, 1'b0, 1'b0, c);
      cycle(1'b1, 32'h2885FFFF, 1'b0, 1'b0, c);
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      check_all_zero("midreset");
      m_valid = 1'b0; m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'h00031100, 1'b0, 1'b1, c);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, c);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
